multi_issue_queue: RTL and testbench



---
 rtl/multi_issue_queue.sv | 124 ++++++++++++
 tb/tb_multi_issue_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multi_issue_queue.sv
// Parametrised N-in/M-out circular issue queue between rename and issue.
// All-or-nothing group push, min(pop,size) pop with overrun pulse, flush.

module miq_out_lane #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int LANE   = 0,
  parameter int AW     = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [AW-1:0]                head,
  input  logic [CNT_W-1:0]             size,
  output logic [DATA_W-1:0]            data,
  output logic                         vld
);
  logic [AW-1:0] idx;

  assign idx  = head + AW'(LANE);
  assign vld  = size > CNT_W'(LANE);
  // Empty lanes read as zero so stale storage never leaks to issue.
  assign data = vld ? mem[idx] : '0;
endmodule

module multi_issue_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [$clog2(IN_W+1)-1:0]  push_num,
  input  logic [IN_W*DATA_W-1:0]     push_data,
  output logic                       push_accept,
  input  logic [$clog2(OUT_W+1)-1:0] pop_num,
  output logic [OUT_W*DATA_W-1:0]    out_data,
  output logic [OUT_W-1:0]           out_valid,
  output logic [CNT_W-1:0]           size,
  output logic [CNT_W-1:0]           size_left,
  output logic                       almost_full,
  output logic                       pop_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(IN_W+1);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [IN_W-1:0][DATA_W-1:0]  push_lanes;
  logic [OUT_W-1:0][DATA_W-1:0] out_lanes;

  logic [AW-1:0]    head_q, tail_q;
  logic [CNT_W-1:0] size_q, size_left_q;
  logic             overrun_q;

  logic [CNT_W-1:0] push_cnt, pop_ext, eff_pop, size_nxt;
  logic             pop_over, push_en;

  assign push_lanes = push_data;

  // Accept uses only registered space; same-cycle pops free nothing yet.
  assign push_accept = CNT_W'(push_num) <= size_left_q;
  assign push_en     = push_accept && !flush;

  always_comb begin
    push_cnt = push_en ? CNT_W'(push_num) : '0;
    pop_ext  = CNT_W'(pop_num);
    pop_over = pop_ext > size_q;
    eff_pop  = pop_over ? size_q : pop_ext;
    size_nxt = size_q + push_cnt - eff_pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      size_q      <= '0;
      size_left_q <= CNT_W'(DEPTH);
      overrun_q   <= 1'b0;
    end else if (flush) begin
      head_q      <= '0;
      tail_q      <= '0;
      size_q      <= '0;
      size_left_q <= CNT_W'(DEPTH);
      overrun_q   <= 1'b0;
    end else begin
      tail_q      <= tail_q + AW'(push_cnt);
      head_q      <= head_q + AW'(eff_pop);
      size_q      <= size_nxt;
      size_left_q <= CNT_W'(DEPTH) - size_nxt;
      overrun_q   <= pop_over;
    end
  end

  // Storage is deliberately unreset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_W; i++)
      if (push_en && (PW'(i) < push_num))
        mem[tail_q + AW'(i)] <= push_lanes[i];
  end

  for (genvar g = 0; g < OUT_W; g++) begin : g_lane
    miq_out_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .LANE   (g),
      .AW     (AW),
      .CNT_W  (CNT_W)
    ) u_lane (
      .mem  (mem),
      .head (head_q),
      .size (size_q),
      .data (out_lanes[g]),
      .vld  (out_valid[g])
    );
  end

  assign out_data    = out_lanes;
  assign size        = size_q;
  assign size_left   = size_left_q;
  assign almost_full = size_left_q < CNT_W'(IN_W);
  assign pop_overrun = overrun_q;
endmodule

// File: tb/tb_multi_issue_queue.sv
// Directed + randomized bench for multi_issue_queue against a queue-based model.

module tb_multi_issue_queue;
  localparam int DEPTH = 16;
  localparam logic [63:0] TAGB = 64'hA500_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   push_num = '0;
  logic [127:0] push_data = '0;
  logic         push_accept;
  logic [1:0]   pop_num = '0;
  logic [127:0] out_data;
  logic [1:0]   out_valid;
  logic [4:0]   size, size_left;
  logic         almost_full, pop_overrun;

  int checks = 0;
  int fails  = 0;
  logic [63:0] mq[$];
  bit exp_ovr = 1'b0;

  always #5 clk = ~clk;

  multi_issue_queue u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_num(push_num), .push_data(push_data), .push_accept(push_accept),
    .pop_num(pop_num), .out_data(out_data), .out_valid(out_valid),
    .size(size), .size_left(size_left), .almost_full(almost_full),
    .pop_overrun(pop_overrun)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = mq.size();
    chk($sformatf("%s:size", tag), 128'(size), 128'(n));
    chk($sformatf("%s:size_left", tag), 128'(size_left), 128'(DEPTH - n));
    chk($sformatf("%s:almost_full", tag), 128'(almost_full), 128'((DEPTH - n) < 2));
    chk($sformatf("%s:pop_overrun", tag), 128'(pop_overrun), 128'(exp_ovr));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s:valid%0d", tag, i), 128'(out_valid[i]), 128'(i < n));
      chk($sformatf("%s:lane%0d", tag, i), 128'(out_data[i*64 +: 64]),
          128'((i < n) ? mq[i] : 64'h0));
    end
  endtask

  task automatic step(input int pn, input int on, input bit fl, input logic [127:0] pd);
    bit acc;
    int eff;
    push_num = 2'(pn); pop_num = 2'(on); flush = fl; push_data = pd;
    #1;
    acc = (pn <= DEPTH - mq.size());
    chk("push_accept", 128'(push_accept), 128'(acc));
    @(posedge clk);
    if (fl) begin
      mq.delete();
      exp_ovr = 1'b0;
    end else begin
      exp_ovr = (on > mq.size());
      eff = exp_ovr ? mq.size() : on;
      repeat (eff) void'(mq.pop_front());
      if (acc) for (int i = 0; i < pn; i++) mq.push_back(pd[i*64 +: 64]);
    end
    #1;
    check_state("step");
    push_num = '0; pop_num = '0; flush = 1'b0;
  endtask

  function automatic logic [127:0] tags(input int a, input int b);
    return {TAGB | 64'(b), TAGB | 64'(a)};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pn, on;
    bit fl;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_state("post_reset");

    // Reset mid-operation
    step(2, 0, 0, rnd128());
    step(2, 0, 0, rnd128());
    step(1, 0, 0, rnd128());
    chk("pre_reset_size", 128'(size), 128'(5));
    push_num = 2'd2;
    #2 rst = 1'b0;
    #1;
    chk("rst_size", 128'(size), 128'(0));
    chk("rst_size_left", 128'(size_left), 128'(16));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_pop_overrun", 128'(pop_overrun), 128'(0));
    chk("rst_push_accept", 128'(push_accept), 128'(1));
    push_num = '0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    exp_ovr = 1'b0;
    check_state("after_reset");
    step(2, 0, 0, rnd128());
    chk("first_push_valid", 128'(out_valid), 128'(2'b11));

    // Fill, then refused push leaves contents intact
    step(0, 0, 1, '0);
    for (int k = 0; k < 8; k++) step(2, 0, 0, tags(2*k, 2*k+1));
    chk("fill_size", 128'(size), 128'(16));
    chk("fill_almost_full", 128'(almost_full), 128'(1));
    step(1, 0, 0, rnd128());
    chk("full_lane0", 128'(out_data[63:0]), 128'(TAGB));

    // Space freed by a same-cycle pop is not reusable
    step(0, 1, 0, '0);
    step(2, 2, 0, rnd128());
    chk("noreuse_size", 128'(size), 128'(13));
    step(2, 0, 0, rnd128());
    chk("reuse_size", 128'(size), 128'(15));

    // Wrap-around
    step(0, 0, 1, '0);
    for (int k = 0; k < 8; k++) step(2, 0, 0, tags(2*k, 2*k+1));
    for (int k = 0; k < 7; k++) step(0, 2, 0, '0);
    step(0, 1, 0, '0);
    step(2, 0, 0, tags(16, 17));
    chk("wrap_lane0", 128'(out_data[63:0]), 128'(TAGB | 64'd15));
    chk("wrap_lane1", 128'(out_data[127:64]), 128'(TAGB | 64'd16));
    step(0, 2, 0, '0);
    chk("wrap_pop_lane0", 128'(out_data[63:0]), 128'(TAGB | 64'd17));

    // Overrun pulse
    step(0, 2, 0, '0);
    chk("ovr_pulse", 128'(pop_overrun), 128'(1));
    chk("ovr_valid", 128'(out_valid), 128'(0));
    step(0, 0, 0, '0);
    chk("ovr_clear", 128'(pop_overrun), 128'(0));

    // Flush priority
    for (int k = 0; k < 3; k++) step(2, 0, 0, rnd128());
    step(2, 2, 1, rnd128());
    chk("flush_size", 128'(size), 128'(0));
    chk("flush_overrun", 128'(pop_overrun), 128'(0));
    step(1, 0, 0, tags(40, 41));
    chk("flush_push_lane0", 128'(out_data[63:0]), 128'(TAGB | 64'd40));

    // Randomized: push-biased phase, then balanced phase
    for (int k = 0; k < 300; k++) begin
      pn = $urandom_range(0, 2);
      if (k < 120) on = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0;
      else on = $urandom_range(0, 2);
      fl = ($urandom_range(0, 24) == 0);
      step(pn, on, fl, rnd128());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
